// File: rtl/msb_mon_pkg.sv
// Shared types and constants for the MSB run monitor.
package msb_mon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    ALARM = 2'd2,
    HOLD  = 2'd3
  } state_e;

  localparam int unsigned RUN_CNT_W = 4;

  // True when the monitor parameters are inside their supported ranges.
  function automatic bit params_legal(input int unsigned run_len,
                                      input int unsigned hold_cycles,
                                      input int unsigned cnt_w);
    return (run_len >= 1) && (run_len <= 15) &&
           (hold_cycles >= 1) && (hold_cycles <= 255) &&
           (cnt_w >= 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all ones; synchronous clear, async active-high reset.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/msb_run_monitor.sv
// Qualifies the upstream MSB flag, detects runs of valid highs, raises a
// stretched alarm, counts alarm entries and emits a rising-edge pulse.
module msb_run_monitor
  import msb_mon_pkg::*;
#(
  parameter int unsigned RUN_LEN     = 3,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flag_valid,
  input  logic                 flag_in,
  input  logic                 clr,
  output logic                 alarm,
  output logic                 rise_pulse,
  output logic [CNT_W-1:0]     event_count,
  output logic [RUN_CNT_W-1:0] run_cnt
);

  localparam int unsigned HOLD_W = 8;

  localparam logic [1:0] S_IDLE  = 2'(IDLE);
  localparam logic [1:0] S_COUNT = 2'(COUNT);
  localparam logic [1:0] S_ALARM = 2'(ALARM);
  localparam logic [1:0] S_HOLD  = 2'(HOLD);

  localparam logic [RUN_CNT_W-1:0] RUN_MAX   = RUN_CNT_W'(RUN_LEN);
  localparam logic [HOLD_W-1:0]    HOLD_INIT = HOLD_W'(HOLD_CYCLES - 1);

  if (!params_legal(RUN_LEN, HOLD_CYCLES, CNT_W)) begin : g_bad_params
    $error("msb_run_monitor: illegal parameter set");
  end

  logic [1:0]           state_q, state_d;
  logic [RUN_CNT_W-1:0] run_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic                 alarm_d;
  logic                 prev_q;
  logic                 evt_inc_c;
  logic                 hi_c, lo_c;

  assign hi_c = flag_valid & flag_in;
  assign lo_c = flag_valid & ~flag_in;

  // Next-state, run counter and hold timer.
  always_comb begin
    state_d   = state_q;
    run_d     = run_cnt;
    hold_d    = hold_q;
    evt_inc_c = 1'b0;
    if (clr) begin
      state_d = S_IDLE;
      run_d   = '0;
      hold_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (hi_c) begin
            run_d = RUN_CNT_W'(1);
            if (RUN_LEN == 1) begin
              state_d   = S_ALARM;
              evt_inc_c = 1'b1;
            end else begin
              state_d = S_COUNT;
            end
          end else if (lo_c) begin
            run_d = '0;
          end
        end
        S_COUNT: begin
          if (hi_c) begin
            run_d = run_cnt + RUN_CNT_W'(1);
            if ((run_cnt + RUN_CNT_W'(1)) == RUN_MAX) begin
              state_d   = S_ALARM;
              evt_inc_c = 1'b1;
            end
          end else if (lo_c) begin
            state_d = S_IDLE;
            run_d   = '0;
          end
        end
        S_ALARM: begin
          if (hi_c) begin
            run_d = RUN_MAX;
          end else if (lo_c) begin
            state_d = S_HOLD;
            hold_d  = HOLD_INIT;
            run_d   = '0;
          end
        end
        S_HOLD: begin
          // A valid high re-arms the alarm ahead of timer expiry.
          if (hi_c) begin
            state_d = S_ALARM;
            run_d   = RUN_MAX;
          end else if (hold_q == '0) begin
            state_d = S_IDLE;
          end else begin
            hold_d = hold_q - HOLD_W'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          run_d   = '0;
          hold_d  = '0;
        end
      endcase
    end
    alarm_d = (state_d == S_ALARM) || (state_d == S_HOLD);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      run_cnt    <= '0;
      hold_q     <= '0;
      alarm      <= 1'b0;
      prev_q     <= 1'b0;
      rise_pulse <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_cnt    <= run_d;
      hold_q     <= hold_d;
      alarm      <= alarm_d;
      rise_pulse <= hi_c & ~prev_q;
      if (flag_valid) begin
        prev_q <= flag_in;
      end
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_event_cnt (
    .clk (clk),
    .rst (rst),
    .inc (evt_inc_c),
    .clr (clr),
    .q   (event_count)
  );

endmodule

// File: tb/tb_msb_run_monitor.sv
// Self-checking bench: three monitor configurations driven in lockstep and
// compared against a run-length/timer reference model.
module tb_msb_run_monitor;

  localparam int NI = 3;
  localparam int RL_P   [NI] = '{3, 3, 1};
  localparam int HOLD_P [NI] = '{4, 4, 1};
  localparam int CMAX_P [NI] = '{255, 3, 255};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flag_valid = 1'b0;
  logic flag_in = 1'b0;
  logic clr = 1'b0;

  logic       alarm_o [NI];
  logic       rise_o  [NI];
  logic [3:0] run_o   [NI];
  logic [7:0] evt_o   [NI];
  logic [7:0] evt0, evt2;
  logic [1:0] evt1;

  assign evt_o[0] = evt0;
  assign evt_o[1] = {6'b0, evt1};
  assign evt_o[2] = evt2;

  always #5 clk = ~clk;

  msb_run_monitor #(.RUN_LEN(3), .HOLD_CYCLES(4), .CNT_W(8)) u_dut0 (
    .clk(clk), .rst(rst), .flag_valid(flag_valid), .flag_in(flag_in), .clr(clr),
    .alarm(alarm_o[0]), .rise_pulse(rise_o[0]), .event_count(evt0), .run_cnt(run_o[0]));

  msb_run_monitor #(.RUN_LEN(3), .HOLD_CYCLES(4), .CNT_W(2)) u_dut1 (
    .clk(clk), .rst(rst), .flag_valid(flag_valid), .flag_in(flag_in), .clr(clr),
    .alarm(alarm_o[1]), .rise_pulse(rise_o[1]), .event_count(evt1), .run_cnt(run_o[1]));

  msb_run_monitor #(.RUN_LEN(1), .HOLD_CYCLES(1), .CNT_W(8)) u_dut2 (
    .clk(clk), .rst(rst), .flag_valid(flag_valid), .flag_in(flag_in), .clr(clr),
    .alarm(alarm_o[2]), .rise_pulse(rise_o[2]), .event_count(evt2), .run_cnt(run_o[2]));

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: length of the current valid-high run, alarm flag and
  // clocks elapsed since the first valid low that ended an alarm (-1 = none).
  int m_run   [NI];
  int m_since [NI];
  int m_evt   [NI];
  bit m_on    [NI];
  bit m_prev  [NI];
  bit m_rise  [NI];

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_run[i] = 0; m_since[i] = -1; m_evt[i] = 0;
      m_on[i] = 0; m_prev[i] = 0; m_rise[i] = 0;
    end
  endtask

  task automatic model_step(input bit v, input bit f, input bit c);
    for (int i = 0; i < NI; i++) begin
      m_rise[i] = v && f && !m_prev[i];
      if (v) m_prev[i] = f;
      if (c) begin
        m_run[i] = 0; m_on[i] = 0; m_since[i] = -1; m_evt[i] = 0;
      end else if (v && f) begin
        m_run[i]++;
        if (m_on[i]) begin
          m_since[i] = -1;
        end else if (m_run[i] >= RL_P[i]) begin
          m_on[i] = 1; m_since[i] = -1;
          if (m_evt[i] < CMAX_P[i]) m_evt[i]++;
        end
      end else begin
        if (v) m_run[i] = 0;
        if (m_on[i] && m_since[i] < 0 && v) begin
          m_since[i] = 0;
        end else if (m_on[i] && m_since[i] >= 0) begin
          m_since[i]++;
          if (m_since[i] == HOLD_P[i]) begin
            m_on[i] = 0; m_since[i] = -1;
          end
        end
      end
    end
  endtask

  function automatic logic [13:0] exp_vec(input int i);
    int r;
    if (m_on[i]) r = (m_since[i] < 0) ? RL_P[i] : 0;
    else         r = (m_run[i] < RL_P[i]) ? m_run[i] : RL_P[i];
    return {m_on[i], m_rise[i], 4'(r), 8'(m_evt[i])};
  endfunction

  function automatic logic [13:0] got_vec(input int i);
    return {alarm_o[i], rise_o[i], run_o[i], evt_o[i]};
  endfunction

  task automatic step(input bit v, input bit f, input bit c);
    flag_valid = v; flag_in = f; clr = c;
    @(posedge clk);
    model_step(v, f, c);
    #1;
  endtask

  task automatic test_reset();
    #12;
    for (int i = 0; i < NI; i++) begin
      n_checks++;
      if (got_vec(i) !== 14'h0) $display("FAIL reset_init inst%0d got %h expected %h", i, got_vec(i), 14'h0);
      else n_pass++;
    end
    @(negedge clk); rst = 1'b0;
    model_reset();
    step(1, 1, 0);
    step(1, 1, 0);
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      n_checks++;
      if (got_vec(i) !== 14'h0) $display("FAIL reset_mid inst%0d got %h expected %h", i, got_vec(i), 14'h0);
      else n_pass++;
    end
    model_reset();
    @(negedge clk); rst = 1'b0;
    flag_valid = 1'b0; flag_in = 1'b0;
  endtask

  task automatic test_run_detect();
    logic [13:0] want;
    for (int k = 1; k <= 3; k++) begin
      step(1, 1, 0);
      want = {(k == 3), (k == 1), 4'(k), 8'(k == 3)};
      n_checks++;
      if (got_vec(0) !== want) $display("FAIL run_detect k%0d got %h expected %h", k, got_vec(0), want);
      else n_pass++;
      for (int i = 0; i < NI; i++) begin
        n_checks++;
        if (got_vec(i) !== exp_vec(i)) $display("FAIL run_detect_model inst%0d got %h expected %h", i, got_vec(i), exp_vec(i));
        else n_pass++;
      end
    end
    step(1, 0, 0);
    for (int k = 0; k < 5; k++) step(0, 0, 0);
  endtask

  task automatic test_broken_run();
    bit seq_v [11] = '{0, 1, 1, 1, 0, 1, 1, 0, 1, 0, 0};
    bit seq_f [11] = '{0, 1, 1, 0, 1, 1, 0, 0, 1, 1, 1};
    step(0, 0, 1);
    for (int k = 0; k < 11; k++) begin
      step(seq_v[k], seq_f[k], 0);
      n_checks++;
      if (got_vec(0) !== exp_vec(0)) $display("FAIL broken_run step%0d got %h expected %h", k, got_vec(0), exp_vec(0));
      else n_pass++;
    end
    n_checks++;
    if (alarm_o[0] !== 1'b0) $display("FAIL broken_run_no_alarm got %0d expected 0", alarm_o[0]);
    else n_pass++;
    step(1, 1, 0);
    step(1, 1, 0);
    n_checks++;
    if ({alarm_o[0], evt_o[0]} !== {1'b1, 8'd1}) $display("FAIL broken_run_alarm got %h expected %h", {alarm_o[0], evt_o[0]}, {1'b1, 8'd1});
    else n_pass++;
    step(1, 0, 0);
    for (int k = 0; k < 5; k++) step(0, 0, 0);
  endtask

  task automatic test_hold_retrigger();
    for (int rep = 0; rep < 2; rep++) begin
      step(1, 1, 0); step(1, 1, 0); step(1, 1, 0);
      step(1, 0, 0);
      for (int k = 1; k <= 4; k++) begin
        if (rep == 1 && k == 4) step(1, 1, 0);
        else step(0, 0, 0);
        n_checks++;
        if (alarm_o[0] !== (rep == 1 || k < 4)) $display("FAIL hold rep%0d k%0d got %0d expected %0d", rep, k, alarm_o[0], (rep == 1 || k < 4));
        else n_pass++;
      end
    end
    step(0, 0, 0); step(0, 0, 0);
    n_checks++;
    if ({alarm_o[0], evt_o[0]} !== {1'b1, 8'd3}) $display("FAIL retrigger_no_event got %h expected %h", {alarm_o[0], evt_o[0]}, {1'b1, 8'd3});
    else n_pass++;
    for (int i = 0; i < NI; i++) begin
      n_checks++;
      if (got_vec(i) !== exp_vec(i)) $display("FAIL hold_model inst%0d got %h expected %h", i, got_vec(i), exp_vec(i));
      else n_pass++;
    end
    step(1, 0, 0);
    for (int k = 0; k < 5; k++) step(0, 0, 0);
  endtask

  task automatic test_saturation_clear();
    int want_evt [5] = '{1, 2, 3, 3, 3};
    step(0, 0, 1);
    for (int e = 0; e < 5; e++) begin
      step(1, 1, 0); step(1, 1, 0); step(1, 1, 0);
      n_checks++;
      if (evt_o[1] !== 8'(want_evt[e])) $display("FAIL saturate ev%0d got %0d expected %0d", e, evt_o[1], want_evt[e]);
      else n_pass++;
      step(1, 0, 0);
      for (int k = 0; k < 5; k++) step(0, 0, 0);
    end
    step(1, 1, 0); step(1, 1, 0);
    step(1, 1, 1);
    n_checks++;
    if ({alarm_o[1], run_o[1], evt_o[1]} !== 13'h0) $display("FAIL clear got %h expected %h", {alarm_o[1], run_o[1], evt_o[1]}, 13'h0);
    else n_pass++;
    for (int i = 0; i < NI; i++) begin
      n_checks++;
      if (got_vec(i) !== exp_vec(i)) $display("FAIL clear_model inst%0d got %h expected %h", i, got_vec(i), exp_vec(i));
      else n_pass++;
    end
    step(1, 0, 0);
    for (int k = 0; k < 5; k++) step(0, 0, 0);
  endtask

  task automatic test_run_len_one();
    step(1, 0, 1);
    step(1, 1, 0);
    n_checks++;
    if (got_vec(2) !== {1'b1, 1'b1, 4'd1, 8'd1}) $display("FAIL run_len_one got %h expected %h", got_vec(2), {1'b1, 1'b1, 4'd1, 8'd1});
    else n_pass++;
    step(1, 0, 0);
    step(0, 0, 0);
    n_checks++;
    if (alarm_o[2] !== 1'b0) $display("FAIL run_len_one_hold got %0d expected 0", alarm_o[2]);
    else n_pass++;
  endtask

  task automatic test_random();
    bit v, f, c;
    for (int k = 0; k < 600; k++) begin
      v = ($urandom_range(3) != 0);
      f = ($urandom_range(4) != 0);
      c = ($urandom_range(47) == 0);
      step(v, f, c);
      for (int i = 0; i < NI; i++) begin
        n_checks++;
        if (got_vec(i) !== exp_vec(i)) $display("FAIL random cyc%0d inst%0d got %h expected %h", k, i, got_vec(i), exp_vec(i));
        else n_pass++;
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_run_detect();
    test_broken_run();
    test_hold_retrigger();
    test_saturation_clear();
    test_run_len_one();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
